// File: rtl/prio_encoder_4to2_bh_if.sv
// Request/result bundle for the registered priority encoder.
// The requester drives I; the encoder returns v and y.
interface prio_encoder_4to2_bh_if #(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned OUT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] I;
    logic             v;
    logic [OUT_W-1:0] y;

    modport master (output I, input v, input y);
    modport slave  (input I, output v, output y);
endinterface

// File: rtl/prio_encoder_4to2_bh.sv
// Registered fixed-priority encoder: index of highest set request bit plus valid.
// One cycle of latency; y and v come straight from flops.
module prio_encoder_4to2_bh #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    prio_encoder_4to2_bh_if.slave bus
);
    localparam int unsigned OUT_W = $clog2(WIDTH);

    logic [OUT_W-1:0] y_d, y_q;
    logic             v_d, v_q;

    // Ascending scan so the last hit, i.e. the highest set bit, wins.
    always_comb begin
        y_d = '0;
        v_d = 1'b0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            if (bus.I[k]) begin
                y_d = OUT_W'(k);
                v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
            v_q <= 1'b0;
        end else begin
            y_q <= y_d;
            v_q <= v_d;
        end
    end

    assign bus.y = y_q;
    assign bus.v = v_q;
endmodule

// File: tb/tb_prio_encoder_4to2_bh.sv
// Directed bench for prio_encoder_4to2_bh at WIDTH=4.
module tb_prio_encoder_4to2_bh;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    prio_encoder_4to2_bh_if #(.WIDTH(4)) bus ();

    prio_encoder_4to2_bh #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic [3:0] i);
        @(negedge clk);
        rst   = r;
        bus.I = i;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int n = 0; n < 2; n++) begin
            step(1'b1, 4'b1111);
            checks++;
            if (bus.y !== 2'b00) begin
                errors++;
                $display("FAIL reset_y cycle %0d: got %b want 00", n, bus.y);
            end
            checks++;
            if (bus.v !== 1'b0) begin
                errors++;
                $display("FAIL reset_v cycle %0d: got %b want 0", n, bus.v);
            end
        end
    endtask

    task automatic test_one_hot();
        logic [3:0] vec [4];
        logic [1:0] exp_y [4];
        vec   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_y = '{2'b00, 2'b01, 2'b10, 2'b11};
        for (int n = 0; n < 4; n++) begin
            step(1'b0, vec[n]);
            checks++;
            if (bus.y !== exp_y[n] || bus.v !== 1'b1) begin
                errors++;
                $display("FAIL one_hot I=%b: got y=%b v=%b want y=%b v=1", vec[n], bus.y, bus.v, exp_y[n]);
            end
        end
    endtask

    task automatic test_zero();
        step(1'b0, 4'b0000);
        checks++;
        if (bus.y !== 2'b00 || bus.v !== 1'b0) begin
            errors++;
            $display("FAIL zero_input: got y=%b v=%b want y=00 v=0", bus.y, bus.v);
        end
    endtask

    task automatic test_multi_hot();
        logic [3:0] vec [3];
        logic [1:0] exp_y [3];
        vec   = '{4'b1011, 4'b0110, 4'b0011};
        exp_y = '{2'b11, 2'b10, 2'b01};
        for (int n = 0; n < 3; n++) begin
            step(1'b0, vec[n]);
            checks++;
            if (bus.y !== exp_y[n] || bus.v !== 1'b1) begin
                errors++;
                $display("FAIL multi_hot I=%b: got y=%b v=%b want y=%b v=1", vec[n], bus.y, bus.v, exp_y[n]);
            end
        end
    endtask

    task automatic test_latency();
        step(1'b0, 4'b0000);
        @(negedge clk);
        bus.I = 4'b0100;
        #1;
        checks++;
        if (bus.y !== 2'b00 || bus.v !== 1'b0) begin
            errors++;
            $display("FAIL latency_no_comb_path: got y=%b v=%b want y=00 v=0", bus.y, bus.v);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.y !== 2'b10 || bus.v !== 1'b1) begin
            errors++;
            $display("FAIL latency_first_edge: got y=%b v=%b want y=10 v=1", bus.y, bus.v);
        end
        step(1'b0, 4'b0000);
        checks++;
        if (bus.y !== 2'b00 || bus.v !== 1'b0) begin
            errors++;
            $display("FAIL latency_second_edge: got y=%b v=%b want y=00 v=0", bus.y, bus.v);
        end
    endtask

    task automatic test_reset_mid_stream();
        step(1'b0, 4'b1000);
        checks++;
        if (bus.y !== 2'b11 || bus.v !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_pre: got y=%b v=%b want y=11 v=1", bus.y, bus.v);
        end
        step(1'b1, 4'b1000);
        checks++;
        if (bus.y !== 2'b00 || bus.v !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_during: got y=%b v=%b want y=00 v=0", bus.y, bus.v);
        end
        step(1'b0, 4'b1000);
        checks++;
        if (bus.y !== 2'b11 || bus.v !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_resume: got y=%b v=%b want y=11 v=1", bus.y, bus.v);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] vec [6];
        logic [1:0] exp_y [6];
        logic       exp_v [6];
        vec   = '{4'b0101, 4'b1111, 4'b0000, 4'b0111, 4'b1001, 4'b0010};
        exp_y = '{2'b10,   2'b11,   2'b00,   2'b10,   2'b11,   2'b01};
        exp_v = '{1'b1,    1'b1,    1'b0,    1'b1,    1'b1,    1'b1};
        for (int n = 0; n < 6; n++) begin
            step(1'b0, vec[n]);
            checks++;
            if (bus.y !== exp_y[n] || bus.v !== exp_v[n]) begin
                errors++;
                $display("FAIL back_to_back I=%b: got y=%b v=%b want y=%b v=%b", vec[n], bus.y, bus.v, exp_y[n], exp_v[n]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.I  = 4'b1111;
        test_reset();
        test_one_hot();
        test_zero();
        test_multi_hot();
        test_latency();
        test_reset_mid_stream();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
